beta_pipe_ctrl: RTL
===================

Name: beta_pipe_ctrl

Overview:
Hazard and exception sequencer for the 5-stage Beta pipeline (IF, RF, ALU, MEM, WB).
- Each cycle it decides per stage latch whether the incoming IR passes, is replaced by the exception BNE, or is replaced by NOP. Each stage has an irsrc select: 0 pass, 1 BNE, 2 NOP.
- It also selects the next PC and the stall/freeze enables.
- It covers load-use stalls, memory-wait freezes, branch annulment, illegal-op traps, interrupts and the post-reset flush.

Parameters:
FLUSH_CYCLES, 3, cycles all irsrc are forced to NOP after reset release
SYNC_STAGES, 2, flops in the irq synchronizer (minimum 2)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rf_ir  in  32  instruction in RF stage
rf_pc31  in  1  supervisor bit of RF-stage PC
alu_ir  in  32  instruction in ALU stage
rf_illop  in  1  RF decode flags an unimplemented opcode
rf_branch  in  1  RF-stage branch/JMP resolved taken
mem_busy  in  1  data memory not ready this cycle
irq  in  1  external interrupt, asynchronous level
pc_stall  out  1  hold PC and IF latch
rf_stall  out  1  hold RF latch
freeze  out  1  hold every pipeline latch
rf_irsrc  out  2  select into RF latch
alu_irsrc  out  2  select into ALU latch
mem_irsrc  out  2  select into MEM latch
pcsel  out  3  0 PC+4, 1 branch target, 2 ILLOP 0x4, 3 XADR 0x8, 4 RESET 0x0
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall or freeze
state  out  2  0 FLUSH, 1 RUN, 2 LDSTALL, 3 FREEZE

Behaviour:
Reset (reset_n low, async):
- state=FLUSH, flush counter=FLUSH_CYCLES, pcsel=4, pc_stall=0, rf_stall=0, freeze=0.
- All irsrc=2, stall_cnt=0, irq synchronizer and pending flag cleared.

FLUSH:
- All irsrc=2, pcsel=4 on the first cycle, 0 after.
- Counter decrements each cycle; go to RUN after FLUSH_CYCLES cycles.
- Inputs are ignored.

Register-read decode of rf_ir (opcode = ir[31:26]):
- ra = ir[20:16] is read unless the opcode is LDR (011111).
- rb = ir[15:11] is read when ir[31:30]=10.
- rc = ir[25:21] is read for ST (011001).

Load-use hazard:
- Condition: alu_ir opcode is LD (011000), alu rc != 31, and alu rc equals any register rf_ir reads.

Priority in RUN (first match wins):
- mem_busy: FREEZE; freeze=1; all irsrc=0 (latches held anyway); pcsel=0.
- load-use: LDSTALL for exactly one cycle; pc_stall=1, rf_stall=1, alu_irsrc=2, others 0. Then RUN and re-evaluate.
- rf_illop: alu_irsrc=1, rf_irsrc=2 (annul IF), pcsel=2.
- irq pending and rf_pc31=0: alu_irsrc=1, rf_irsrc=2, pcsel=3; clear pending.
- rf_branch: rf_irsrc=2, pcsel=1.
- Otherwise: all 0, pcsel=0.

FREEZE:
- Stay in FREEZE while mem_busy=1. No hazard or trap is evaluated.
- Pending irq is retained.
- Exit to RUN the cycle mem_busy falls; decisions resume that cycle.

Interrupt handling:
- irq passes through SYNC_STAGES flops; a synchronized high sets the pending flag (level; re-sets while irq is held).
- Pending is never taken in supervisor mode (rf_pc31=1), during LDSTALL, or when rf_illop is also asserted.
- In that last case illop wins and irq stays pending.

Other rules:
- A load-use hazard suppresses a simultaneous rf_branch/rf_illop; they are re-evaluated next cycle with the same RF instruction.
- stall_cnt increments each cycle pc_stall|freeze=1 and saturates at all-ones.
- All outputs are combinational from state plus inputs, except stall_cnt, state and pending, which are registered.

Test Plan:
- Reset release: reset_n low then high -> 3 cycles of all irsrc=2 with pcsel=4 on the first, then state=1, pcsel=0.
- Load-use: alu_ir=LD R1←[R2+4], rf_ir=ADD R3←R1,R4 -> one cycle pc_stall=1, rf_stall=1, alu_irsrc=2, stall_cnt+1; next cycle all 0. Repeat with alu rc=31 -> no stall.
- Illop and irq together in user mode: rf_illop=1, irq held, rf_pc31=0 -> alu_irsrc=1, pcsel=2; next cycle irq taken with pcsel=3.
- Supervisor mode: irq held with rf_pc31=1 for 10 cycles -> pcsel never 3; first cycle with rf_pc31=0 -> pcsel=3, rf_irsrc=2, pending cleared.
- Memory wait with branch: mem_busy high 5 cycles with rf_branch=1 -> freeze=1 for 5 cycles, stall_cnt=5, pcsel=0; the cycle mem_busy falls -> pcsel=1, rf_irsrc=2.
- Reset mid-stall: reset_n low during FREEZE -> outputs immediately at reset values, stall_cnt=0.

Source files
------------

// File: rtl/beta_pipe_ctrl.sv
// Hazard/exception sequencer for the 5-stage Beta pipeline: per-latch IR
// source selects, next-PC select, stall/freeze enables and a stall counter.
module beta_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      rf_ir,
  input  logic             rf_pc31,
  input  logic [31:0]      alu_ir,
  input  logic             rf_illop,
  input  logic             rf_branch,
  input  logic             mem_busy,
  input  logic             irq,
  output logic             pc_stall,
  output logic             rf_stall,
  output logic             freeze,
  output logic [1:0]       rf_irsrc,
  output logic [1:0]       alu_irsrc,
  output logic [1:0]       mem_irsrc,
  output logic [2:0]       pcsel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] IR_PASS = 2'd0;
  localparam logic [1:0] IR_BNE  = 2'd1;
  localparam logic [1:0] IR_NOP  = 2'd2;

  localparam logic [2:0] PC_INC   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_ILLOP = 3'd2;
  localparam logic [2:0] PC_XADR  = 3'd3;
  localparam logic [2:0] PC_RESET = 3'd4;

  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_LDR = 6'b011111;

  typedef enum logic [1:0] {
    S_FLUSH   = 2'd0,
    S_RUN     = 2'd1,
    S_LDSTALL = 2'd2,
    S_FREEZE  = 2'd3
  } state_t;

  state_t                 st, st_nxt;
  logic [FW-1:0]          flush_cnt;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   irq_s;
  logic                   pending;
  logic                   take;
  logic                   ld_use;
  logic [4:0]             alu_rc;
  logic                   rd_ra, rd_rb, rd_rc;

  assign irq_s  = irq_sync[SYNC_STAGES-1];
  assign alu_rc = alu_ir[25:21];
  assign rd_ra  = (rf_ir[31:26] != OP_LDR)   && (rf_ir[20:16] == alu_rc);
  assign rd_rb  = (rf_ir[31:30] == 2'b10)    && (rf_ir[15:11] == alu_rc);
  assign rd_rc  = (rf_ir[31:26] == OP_ST)    && (rf_ir[25:21] == alu_rc);
  // R31 reads as zero, so a load targeting it never creates a hazard.
  assign ld_use = (alu_ir[31:26] == OP_LD) && (alu_rc != 5'd31) &&
                  (rd_ra || rd_rb || rd_rc);
  assign state  = st;

  always_comb begin
    pc_stall  = 1'b0;
    rf_stall  = 1'b0;
    freeze    = 1'b0;
    rf_irsrc  = IR_PASS;
    alu_irsrc = IR_PASS;
    mem_irsrc = IR_PASS;
    pcsel     = PC_INC;
    take      = 1'b0;
    st_nxt    = st;
    case (st)
      S_FLUSH: begin
        rf_irsrc  = IR_NOP;
        alu_irsrc = IR_NOP;
        mem_irsrc = IR_NOP;
        pcsel     = (flush_cnt == FW'(FLUSH_CYCLES)) ? PC_RESET : PC_INC;
        if (flush_cnt <= FW'(1)) st_nxt = S_RUN;
      end
      default: begin
        // LDSTALL is the cycle right after the bubble: same RF instruction is
        // re-decoded, but no second stall and no interrupt entry.
        st_nxt = S_RUN;
        if (mem_busy) begin
          freeze = 1'b1;
          st_nxt = S_FREEZE;
        end else if (ld_use && st != S_LDSTALL) begin
          pc_stall  = 1'b1;
          rf_stall  = 1'b1;
          alu_irsrc = IR_NOP;
          st_nxt    = S_LDSTALL;
        end else if (rf_illop) begin
          alu_irsrc = IR_BNE;
          rf_irsrc  = IR_NOP;
          pcsel     = PC_ILLOP;
        end else if (pending && !rf_pc31 && st != S_LDSTALL) begin
          alu_irsrc = IR_BNE;
          rf_irsrc  = IR_NOP;
          pcsel     = PC_XADR;
          take      = 1'b1;
        end else if (rf_branch) begin
          rf_irsrc = IR_NOP;
          pcsel    = PC_BR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= S_FLUSH;
      flush_cnt <= FW'(FLUSH_CYCLES);
      irq_sync  <= '0;
      pending   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      st       <= st_nxt;
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq};
      if (st == S_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
      // Taking the trap clears pending; a still-high irq re-arms it next cycle.
      if (take)                         pending <= 1'b0;
      else if (irq_s && st != S_FLUSH)  pending <= 1'b1;
      if ((pc_stall || freeze) && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
